fabric_mem_ld_arbiter: RTL and testbench

Round-robin load-request arbiter that shares one tagged load port of a `fabric_memory` instance among `NUM_REQ` independent requesters. Each granted request is stamped with the requester index as its tag and registered onto the memory load-address stream. Returning load data is demultiplexed back to the owning requester by tag. Per-requester outstanding-request credits bound the number of in-flight loads, and malformed responses are reported through the standard sticky error interface.

---
 rtl/fabric_mem_ld_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fabric_mem_ld_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_mem_ld_arbiter.sv
// Round-robin arbiter sharing one tagged fabric_memory load port among NUM_REQ requesters,
// with per-requester credit limits, tag-based response demux and a sticky error report.

module fabric_mem_ld_credit #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             req_valid_i,
  output logic             elig_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating at both ends; simultaneous inc/dec cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CNT_W'(MAX_OUTSTANDING))
      cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign elig_o = req_valid_i && (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign cnt_o  = cnt_q;
endmodule

module fabric_mem_ld_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int ADDR_WIDTH      = 6,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int TAG_WIDTH       = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]        mem_req_data,
  input  logic                                   mem_resp_valid,
  output logic                                   mem_resp_ready,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]        mem_resp_data,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  input  logic [NUM_REQ-1:0]                     rsp_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     rsp_data,
  output logic                                   error_valid,
  output logic [15:0]                            error_code
);
  localparam int          PW                        = DATA_WIDTH + TAG_WIDTH;
  localparam logic [15:0] RT_MEMARB_TAG_OOB         = 16'h0A01;
  localparam logic [15:0] RT_MEMARB_RESP_UNEXPECTED = 16'h0A02;

  logic                          mreq_vld_q, mreq_vld_d;
  logic [PW-1:0]                 mreq_data_q, mreq_data_d;
  logic [TAG_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
  logic                          err_vld_q, err_vld_d;
  logic [15:0]                   err_code_q, err_code_d;

  logic [NUM_REQ-1:0]            elig, grant, inc, dec;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
  logic                          gnt_any, load_en, tag_oob, rsp_hit;
  logic [TAG_WIDTH-1:0]          gnt_idx, rsp_tag;

  fabric_mem_ld_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_credit [NUM_REQ-1:0] (
    .clk(clk), .rst(rst), .inc_i(inc), .dec_i(dec),
    .req_valid_i(req_valid), .elig_o(elig), .cnt_o(cnt)
  );

  assign load_en = !mreq_vld_q || mem_req_ready;

  // Search eligible requesters starting at rr_ptr; first hit wins.
  always_comb begin
    int                   j;
    logic [TAG_WIDTH-1:0] idx;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j   = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx = TAG_WIDTH'(j);
      if (!gnt_any && elig[idx]) begin
        gnt_any    = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign req_ready = (rst || !load_en) ? '0 : grant;
  assign inc       = req_valid & req_ready;
  assign dec       = rsp_valid & rsp_ready;

  always_comb begin
    mreq_vld_d  = mreq_vld_q;
    mreq_data_d = mreq_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      mreq_vld_d = gnt_any;
      if (gnt_any) begin
        mreq_data_d                          = '0;
        mreq_data_d[ADDR_WIDTH-1:0]          = req_addr[gnt_idx];
        mreq_data_d[DATA_WIDTH +: TAG_WIDTH] = gnt_idx;
        rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + TAG_WIDTH'(1);
      end
    end
  end

  // Responses with a bad tag or no outstanding credit are swallowed (ready held high).
  assign rsp_tag = mem_resp_data[DATA_WIDTH +: TAG_WIDTH];
  assign tag_oob = int'(rsp_tag) >= NUM_REQ;

  always_comb begin
    rsp_valid      = '0;
    mem_resp_ready = 1'b1;
    rsp_hit        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!tag_oob && int'(rsp_tag) == i && cnt[i] != '0) begin
        rsp_valid[i]   = mem_resp_valid;
        mem_resp_ready = rsp_ready[i];
        rsp_hit        = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_data
    assign rsp_data[g] = mem_resp_data[DATA_WIDTH-1:0];
  end

  always_comb begin
    err_vld_d  = err_vld_q;
    err_code_d = err_code_q;
    if (!err_vld_q && mem_resp_valid) begin
      if (tag_oob) begin
        err_vld_d  = 1'b1;
        err_code_d = RT_MEMARB_TAG_OOB;
      end else if (!rsp_hit) begin
        err_vld_d  = 1'b1;
        err_code_d = RT_MEMARB_RESP_UNEXPECTED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mreq_vld_q  <= 1'b0;
      mreq_data_q <= '0;
      rr_ptr_q    <= '0;
      err_vld_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      mreq_vld_q  <= mreq_vld_d;
      mreq_data_q <= mreq_data_d;
      rr_ptr_q    <= rr_ptr_d;
      err_vld_q   <= err_vld_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_req_valid = mreq_vld_q;
  assign mem_req_data  = mreq_data_q;
  assign error_valid   = err_vld_q;
  assign error_code    = err_code_q;
endmodule

// File: tb/tb_fabric_mem_ld_arbiter.sv
// Scoreboard bench: stimulus pushes expected memory requests / requester responses,
// negedge monitors pop and compare on each handshake; direct checks cover flow control.

module tb_fabric_mem_ld_arbiter;
  localparam logic [15:0] E_OOB   = 16'h0A01;
  localparam logic [15:0] E_UNEXP = 16'h0A02;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: NUM_REQ = 4, defaults
  logic [3:0]         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0][5:0]    req_addr;
  logic               mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready, error_valid;
  logic [33:0]        mem_req_data, mem_resp_data;
  logic [3:0][31:0]   rsp_data;
  logic [15:0]        error_code;

  // DUT B: NUM_REQ = 3, tag 3 is out of range
  logic [2:0]         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [2:0][5:0]    b_req_addr;
  logic               b_mem_req_valid, b_mem_req_ready, b_mem_resp_valid, b_mem_resp_ready, b_error_valid;
  logic [33:0]        b_mem_req_data, b_mem_resp_data;
  logic [2:0][31:0]   b_rsp_data;
  logic [15:0]        b_error_code;

  fabric_mem_ld_arbiter u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .error_valid(error_valid), .error_code(error_code)
  );

  fabric_mem_ld_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_data(b_mem_req_data),
    .mem_resp_valid(b_mem_resp_valid), .mem_resp_ready(b_mem_resp_ready), .mem_resp_data(b_mem_resp_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .error_valid(b_error_valid), .error_code(b_error_code)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [33:0] qreq[$];
  logic [33:0] qrsp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] req_word(input int tag, input int addr);
    logic [33:0] w;
    w        = '0;
    w[5:0]   = 6'(addr);
    w[33:32] = 2'(tag);
    return w;
  endfunction

  function automatic logic [33:0] rsp_word(input int tag, input logic [31:0] data);
    return {2'(tag), data};
  endfunction

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic send_rsp(input int tag, input logic [31:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_data  = rsp_word(tag, data);
    qrsp.push_back(rsp_word(tag, data));
    mid();
    chk("rsp_mem_ready", 64'(mem_resp_ready), 64'd1);
    step();
    mem_resp_valid = 1'b0;
  endtask

  // Request-side monitor
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (qreq.size() == 0) chk("mem_req_unexpected", 64'(mem_req_data), 64'h3_FFFF_FFFF_F);
      else chk("mem_req_data", 64'(mem_req_data), 64'(qreq.pop_front()));
    end
  end

  // Response-side monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (qrsp.size() == 0) chk("rsp_unexpected", 64'(i), 64'hFF);
          else begin
            logic [33:0] e;
            e = qrsp.pop_front();
            chk("rsp_lane", 64'(i), 64'(e[33:32]));
            chk("rsp_data", 64'(rsp_data[i]), 64'(e[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '1; req_addr = {6'd13, 6'd12, 6'd11, 6'd10};
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; rsp_ready = '1;
    b_req_valid = '0; b_req_addr = '0; b_mem_req_ready = 1'b1;
    b_mem_resp_valid = 1'b0; b_mem_resp_data = '0; b_rsp_ready = '1;

    // Reset state
    mid();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_req_data", 64'(mem_req_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_error_valid", 64'(error_valid), 64'd0);
    chk("rst_error_code", 64'(error_code), 64'd0);
    chk("rst_b_error_valid", 64'(b_error_valid), 64'd0);
    step();
    rst = 1'b0; req_valid = '0;

    // NUM_REQ=3: out-of-range tag, then an unexpected response must not overwrite the code
    b_mem_resp_valid = 1'b1; b_mem_resp_data = {2'd3, 32'h3333_3333};
    mid();
    chk("b_oob_resp_ready", 64'(b_mem_resp_ready), 64'd1);
    chk("b_oob_rsp_valid", 64'(b_rsp_valid), 64'd0);
    step();
    b_mem_resp_data = {2'd0, 32'h0000_0001};
    mid();
    chk("b_oob_err_valid", 64'(b_error_valid), 64'd1);
    chk("b_oob_err_code", 64'(b_error_code), 64'(E_OOB));
    step();
    b_mem_resp_valid = 1'b0;
    mid();
    chk("b_err_code_kept", 64'(b_error_code), 64'(E_OOB));
    step();

    // Fairness: all four valid, tags 0,1,2,3,0
    mem_req_ready = 1'b1; req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      qreq.push_back(req_word(k % 4, 10 + k % 4));
      mid();
      chk("rr_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      step();
    end
    req_valid = '0;
    send_rsp(0, 32'hA000_0000);
    send_rsp(0, 32'hA000_0001);
    send_rsp(1, 32'hA000_0002);
    send_rsp(2, 32'hA000_0003);
    send_rsp(3, 32'hA000_0004);

    // Credit limit on requester 2
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      req_addr[2] = 6'(5 + k);
      qreq.push_back(req_word(2, 5 + k));
      mid();
      chk("cred_accept", 64'(req_ready), 64'b0100);
      step();
    end
    req_addr[2] = 6'd9;
    mid();
    chk("cred_block", 64'(req_ready), 64'd0);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = rsp_word(2, 32'h0000_0205);
    qrsp.push_back(rsp_word(2, 32'h0000_0205));
    mid();
    chk("cred_no_comb_path", 64'(req_ready), 64'd0);
    chk("cred_rsp_valid", 64'(rsp_valid), 64'b0100);
    step();
    mem_resp_valid = 1'b0;
    qreq.push_back(req_word(2, 9));
    mid();
    chk("cred_reissue", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) send_rsp(2, 32'hB000_0000 + 32'(k));

    // Back-pressure: register held, rr_ptr does not move while stalled
    mem_req_ready = 1'b0; req_valid = 4'b0010;
    req_addr = {6'd13, 6'd12, 6'd33, 6'd10};
    qreq.push_back(req_word(1, 33));
    mid();
    chk("bp_first_load", 64'(req_ready), 64'b0010);
    step();
    req_valid = '1; req_addr[1] = 6'd34;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_valid_held", 64'(mem_req_valid), 64'd1);
      chk("bp_data_held", 64'(mem_req_data), 64'(req_word(1, 33)));
      step();
    end
    mem_req_ready = 1'b1;
    qreq.push_back(req_word(2, 12));
    mid();
    chk("bp_rr_next", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;

    // Response held by requester back-pressure
    send_rsp(2, 32'h0000_0022);
    rsp_ready = 4'b1101;
    mem_resp_valid = 1'b1; mem_resp_data = rsp_word(1, 32'hDEAD_BEEF);
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("hold_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("hold_mem_ready", 64'(mem_resp_ready), 64'd0);
      chk("hold_rsp_data", 64'(rsp_data[1]), 64'hDEAD_BEEF);
      step();
    end
    rsp_ready = '1;
    qrsp.push_back(rsp_word(1, 32'hDEAD_BEEF));
    mid();
    chk("hold_release", 64'(mem_resp_ready), 64'd1);
    step();
    // Credit now 0: repeating the response is unexpected
    mid();
    chk("unexp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("unexp_mem_ready", 64'(mem_resp_ready), 64'd1);
    chk("unexp_not_yet", 64'(error_valid), 64'd0);
    step();
    mem_resp_valid = 1'b0;
    mid();
    chk("unexp_err_valid", 64'(error_valid), 64'd1);
    chk("unexp_err_code", 64'(error_code), 64'(E_UNEXP));
    step();

    // Simultaneous grant and response on requester 0 keeps the credit count
    req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      qreq.push_back(req_word(0, 10));
      mid();
      chk("same_pre", 64'(req_ready), 64'b0001);
      step();
    end
    qreq.push_back(req_word(0, 10));
    mem_resp_valid = 1'b1; mem_resp_data = rsp_word(0, 32'h0000_0C0C);
    qrsp.push_back(rsp_word(0, 32'h0000_0C0C));
    mid();
    chk("same_req_ready", 64'(req_ready), 64'b0001);
    chk("same_rsp_valid", 64'(rsp_valid), 64'b0001);
    step();
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) qreq.push_back(req_word(0, 10));
      mid();
      chk("same_fill", 64'(req_ready), (k < 2) ? 64'b0001 : 64'd0);
      step();
    end

    // Asynchronous reset with a request held in the register and credits outstanding
    req_valid = 4'b0010; mem_req_ready = 1'b0;
    mid();
    chk("rst_pre_grant", 64'(req_ready), 64'b0010);
    step();
    mem_resp_valid = 1'b1; mem_resp_data = rsp_word(0, 32'h0000_0E0E);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_mem_req_data", 64'(mem_req_data), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_err_valid", 64'(error_valid), 64'd0);
    chk("arst_err_code", 64'(error_code), 64'd0);
    step();
    rst = 1'b0; req_valid = '0;
    mid();
    chk("post_rst_drop", 64'(rsp_valid), 64'd0);
    chk("post_rst_ready", 64'(mem_resp_ready), 64'd1);
    step();
    mem_resp_valid = 1'b0;
    mid();
    chk("post_rst_err", 64'(error_code), 64'(E_UNEXP));
    chk("q_req_empty", 64'(qreq.size()), 64'd0);
    chk("q_rsp_empty", 64'(qrsp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
